alu_serial: RTL and testbench
=============================

# alu_serial

Parametrised, digit-serial successor to the 16-bit ripple ALU. Processes a WIDTH-bit operation SLICE bits per clock, holding the inter-slice carry in a register, and exposes result and status flags over a valid/ready handshake. Sits between the operand register file and the writeback stage, where area matters more than single-cycle latency. Keeps a persistent carry flag for multi-word ADC/SBB chains.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle; N = WIDTH/SLICE slice cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; the only reset.
- in_valid  input  1  operation request.
- in_ready  output  1  high only in IDLE.
- op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 ADC, 110 SBB, 111 PASS (o = i1).
- i0, i1  input  WIDTH  operands, captured on accept.
- out_valid  output  1  result available (DONE state).
- out_ready  input  1  consumer accepts result.
- o  output  WIDTH  result.
- cout  output  1  carry out of the MSB slice (arith ops), 0 for logic/PASS.
- zero, neg, ovf  output  1  each  status flags (see Configuration).

## Operation
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE: in_ready=1. Accept on in_valid && in_ready: latch op, i0, i1; clear slice index; preload carry register with cin; go RUN.
- cin: ADD 0, SUB 1, ADC = stored carry flag C, SBB = C; SUB/SBB invert i1.
- RUN: each cycle compute slice k (bits k*SLICE .. k*SLICE+SLICE-1) from latched operands and carry register; write into result register; update carry register; k increments. After slice N-1 go DONE.
- DONE: out_valid=1; o, cout, flags held stable until out_valid && out_ready; then IDLE.
- SUB/SBB cout = NOT borrow (1 when i0 >= i1 unsigned, SUB case).
- Stored flag C updated at DONE entry by ADD/SUB/ADC/SBB only; logic ops and PASS leave C unchanged.
- ovf: signed overflow of arith ops (carry into MSB XOR carry out); 0 for logic/PASS.
- zero = (o == 0); neg = o[WIDTH-1].
- in_valid in RUN/DONE ignored (in_ready=0); operand changes after accept have no effect.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, o=0, cout=0, zero=0, neg=0, ovf=0, C=0.
- Accept at edge E0; slices processed at edges E1..EN; out_valid rises after EN (N cycles after accept).
- Minimum issue interval N+2 cycles (accept, N slices, one DONE cycle with out_ready=1, back to IDLE next edge).
- Back-to-back: in_ready returns to 1 the cycle after the output transfer; no overlap with DONE.
- out_ready held low: DONE persists indefinitely, outputs unchanged.
- SLICE == WIDTH: N=1, single RUN cycle.
- Reset asserted mid-RUN/DONE: immediate return to reset values; partial result discarded; C cleared.
- o and flags are registered; no combinational path from inputs to outputs.

## Configuration
- ALU_FLAGS_EN defined: zero, neg, ovf computed and registered as above.
- ALU_FLAGS_EN undefined: zero, neg, ovf tied to 0, their registers and logic removed; o, cout, C and ADC/SBB behaviour unchanged.

## Test plan
- WIDTH=16, SLICE=4: ADD 0xFFFF + 0x0001 -> o=0x0000, cout=1, zero=1, ovf=0; out_valid exactly 4 cycles after accept.
- SUB 0x0003 - 0x0005 -> o=0xFFFE, cout=0, neg=1; following SBB 0x0000 - 0x0000 -> o=0xFFFF (borrow propagated), cout=0.
- ADD 0xFFFF + 0x0001 then ADC 0x0000 + 0x0000 -> second o=0x0001, cout=0; intervening XOR does not alter C.
- SUB 0x8000 - 0x0001 -> o=0x7FFF, ovf=1, neg=0; AND 0xF0F0 & 0x0FF0 -> 0x00F0, cout=0, ovf=0.
- Backpressure: out_ready low 5 cycles in DONE -> o/flags stable, in_ready=0, new in_valid ignored; transfer then in_ready=1 next cycle.
- Reset asserted on second RUN cycle -> all outputs zero, in_ready=1 same cycle; fresh ADD 0x0002+0x0003 -> 0x0005 with C=0 used.

Source files
------------

// File: rtl/alu_serial.sv
// alu_serial: digit-serial ALU. Processes a WIDTH-bit operation SLICE bits per clock
// (N = WIDTH/SLICE slice cycles), holding the inter-slice carry in a register.
// A persistent carry flag C supports multi-word ADC/SBB chains.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   operation request; accepted only while in_ready is high (IDLE)
//   in_ready   high only in IDLE
//   op         000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 ADC, 110 SBB, 111 PASS
//   i0, i1     operands, captured on accept
//   out_valid  result available (DONE)
//   out_ready  consumer accepts result
//   o          result
//   cout       carry out of the MSB (arith ops; SUB/SBB give NOT borrow), 0 otherwise
//   zero, neg, ovf  status flags
//
// Configuration macro: ALU_FLAGS_EN. When defined, zero/neg/ovf are computed and
// registered; when undefined they are tied to 0 and their logic is absent.

module alu_serial #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int unsigned N    = WIDTH / SLICE;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpSub  = 3'b001;
  localparam logic [2:0] OpAnd  = 3'b010;
  localparam logic [2:0] OpOr   = 3'b011;
  localparam logic [2:0] OpXor  = 3'b100;
  localparam logic [2:0] OpAdc  = 3'b101;
  localparam logic [2:0] OpSbb  = 3'b110;
  localparam logic [2:0] OpPass = 3'b111;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  o_q, o_d;
  logic              cout_q, cout_d;
  logic              c_flag_q, c_flag_d;
`ifdef ALU_FLAGS_EN
  logic              zero_q, zero_d;
  logic              neg_q, neg_d;
  logic              ovf_q, ovf_d;
  logic              carry_msb_in;
`endif

  logic              in_arith;
  logic              in_inv;
  logic              in_cin;
  logic              run_arith;
  logic [SLICE-1:0]  slice_a;
  logic [SLICE-1:0]  slice_b;
  logic [SLICE:0]    slice_sum;
  logic [SLICE-1:0]  slice_res;
  logic [WIDTH-1:0]  res_next;
  logic              last_slice;

  always_comb begin
    // Decode of the incoming request
    in_arith = (op == OpAdd) || (op == OpSub) || (op == OpAdc) || (op == OpSbb);
    in_inv   = (op == OpSub) || (op == OpSbb);
    unique case (op)
      OpSub:        in_cin = 1'b1;
      OpAdc, OpSbb: in_cin = c_flag_q;
      default:      in_cin = 1'b0;
    endcase

    run_arith = (op_q == OpAdd) || (op_q == OpSub) || (op_q == OpAdc) || (op_q == OpSbb);

    // Operands shift right each RUN cycle, so the active slice is always the low bits
    slice_a   = a_q[SLICE-1:0];
    slice_b   = b_q[SLICE-1:0];
    slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE{1'b0}}, carry_q};

    unique case (op_q)
      OpAnd:   slice_res = slice_a & slice_b;
      OpOr:    slice_res = slice_a | slice_b;
      OpXor:   slice_res = slice_a ^ slice_b;
      OpPass:  slice_res = slice_b;
      default: slice_res = slice_sum[SLICE-1:0];
    endcase

    // Result fills in from the top; after N shifts it is fully aligned
    res_next   = (o_q >> SLICE) | (WIDTH'(slice_res) << (WIDTH - SLICE));
    last_slice = (idx_q == IdxW'(N - 1));

`ifdef ALU_FLAGS_EN
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB is recoverable from it
    carry_msb_in = slice_a[SLICE-1] ^ slice_b[SLICE-1] ^ slice_sum[SLICE-1];
`endif

    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    o_d      = o_q;
    cout_d   = cout_q;
    c_flag_d = c_flag_q;
`ifdef ALU_FLAGS_EN
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d    = op;
          a_d     = i0;
          b_d     = in_inv ? ~i1 : i1;
          idx_d   = '0;
          carry_d = in_arith ? in_cin : 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        o_d     = res_next;
        carry_d = run_arith ? slice_sum[SLICE] : 1'b0;
        idx_d   = idx_q + IdxW'(1);
        if (last_slice) begin
          state_d = StDone;
          cout_d  = run_arith & slice_sum[SLICE];
          if (run_arith) begin
            c_flag_d = slice_sum[SLICE];
          end
`ifdef ALU_FLAGS_EN
          zero_d = (res_next == '0);
          neg_d  = res_next[WIDTH-1];
          ovf_d  = run_arith & (carry_msb_in ^ slice_sum[SLICE]);
`endif
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    o         = o_q;
    cout      = cout_q;
`ifdef ALU_FLAGS_EN
    zero      = zero_q;
    neg       = neg_q;
    ovf       = ovf_q;
`else
    zero      = 1'b0;
    neg       = 1'b0;
    ovf       = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= 3'b000;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      o_q      <= '0;
      cout_q   <= 1'b0;
      c_flag_q <= 1'b0;
`ifdef ALU_FLAGS_EN
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      o_q      <= o_d;
      cout_q   <= cout_d;
      c_flag_q <= c_flag_d;
`ifdef ALU_FLAGS_EN
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_serial.sv
module tb_alu_serial;

  localparam int unsigned W = 16;
  localparam int unsigned S = 4;
  localparam int unsigned NSL = W / S;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] i0 = '0;
  logic [W-1:0] i1 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] o;
  logic         cout;
  logic         zero;
  logic         neg;
  logic         ovf;

  int tests = 0;
  int fails = 0;
  logic model_c = 1'b0;

  alu_serial #(.WIDTH(W), .SLICE(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .i0        (i0),
    .i1        (i1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .cout      (cout),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: whole-word arithmetic straight from the op definitions
  function automatic void model(input logic [2:0] opc, input logic [15:0] a,
                                input logic [15:0] b, input logic cf,
                                output logic [15:0] r, output logic co,
                                output logic ov, output logic arith);
    logic [16:0] s;
    logic [15:0] bb;
    s = '0;
    bb = b;
    arith = 1'b1;
    case (opc)
      3'b000: s = {1'b0, a} + {1'b0, b};
      3'b001: begin bb = ~b; s = {1'b0, a} + {1'b0, bb} + 17'd1; end
      3'b101: s = {1'b0, a} + {1'b0, b} + {16'd0, cf};
      3'b110: begin bb = ~b; s = {1'b0, a} + {1'b0, bb} + {16'd0, cf}; end
      3'b010: begin arith = 1'b0; s = {1'b0, a & b}; end
      3'b011: begin arith = 1'b0; s = {1'b0, a | b}; end
      3'b100: begin arith = 1'b0; s = {1'b0, a ^ b}; end
      default: begin arith = 1'b0; s = {1'b0, b}; end
    endcase
    r  = s[15:0];
    co = arith & s[16];
    ov = arith & (a[15] == bb[15]) & (r[15] != a[15]);
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_o"}, {16'd0, o}, 32'd0);
    chk({tag, "_cout"}, {31'd0, cout}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_flags"}, {29'd0, zero, neg, ovf}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] opc, input logic [15:0] a,
                        input logic [15:0] b, input int hold);
    logic [15:0] er;
    logic        eco, eov, ear;
    logic [2:0]  ef;
    int          cyc;
    model(opc, a, b, model_c, er, eco, eov, ear);
`ifdef ALU_FLAGS_EN
    ef = {(er == 16'd0), er[15], eov};
`else
    ef = 3'b000;
`endif
    @(posedge clk); #1;
    chk({tag, "_in_ready_idle"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; op = opc; i0 = a; i1 = b;
    @(posedge clk); #1;
    // Post-accept operand changes must not matter
    in_valid = 1'b0; op = 3'($urandom); i0 = 16'($urandom); i1 = 16'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, cyc, NSL);
    chk({tag, "_o"}, {16'd0, o}, {16'd0, er});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, eco});
    chk({tag, "_flags"}, {29'd0, zero, neg, ovf}, {29'd0, ef});
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; op = 3'($urandom); i0 = 16'($urandom); i1 = 16'($urandom);
      @(posedge clk); #1;
      chk({tag, "_hold_o"}, {15'd0, o, cout}, {15'd0, er, eco});
      chk({tag, "_hold_flags"}, {29'd0, zero, neg, ovf}, {29'd0, ef});
      chk({tag, "_hold_hs"}, {30'd0, out_valid, in_ready}, 32'd2);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_after_xfer"}, {30'd0, out_valid, in_ready}, 32'd1);
    if (ear) model_c = eco;
  endtask

  initial begin
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    run_op("add_wrap", 3'b000, 16'hFFFF, 16'h0001, 0);
    run_op("sub_neg", 3'b001, 16'h0003, 16'h0005, 0);
    run_op("sbb_borrow", 3'b110, 16'h0000, 16'h0000, 0);
    run_op("add_carry", 3'b000, 16'hFFFF, 16'h0001, 0);
    run_op("xor_keepc", 3'b100, 16'h1234, 16'h00FF, 0);
    run_op("adc_chain", 3'b101, 16'h0000, 16'h0000, 0);
    run_op("sub_ovf", 3'b001, 16'h8000, 16'h0001, 0);
    run_op("and", 3'b010, 16'hF0F0, 16'h0FF0, 0);
    run_op("bp_pass", 3'b111, 16'hABCD, 16'h5A5A, 5);
    run_op("set_c", 3'b000, 16'hFFFF, 16'h0001, 0);

    // Reset during the second RUN cycle
    @(posedge clk); #1;
    in_valid = 1'b1; op = 3'b000; i0 = 16'h1111; i1 = 16'h1111;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    model_c = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    run_op("post_reset_add", 3'b000, 16'h0002, 16'h0003, 0);
    run_op("post_reset_adc", 3'b101, 16'h0000, 16'h0000, 0);

    for (int n = 0; n < 40; n++) begin
      run_op("rand", 3'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
